// File: rtl/multiplexed_display_pkg.sv
// Shared constants for the multiplexed four-digit seven-segment display:
// digit codes, active-low segment patterns and the anode decode helper.
package multiplexed_display_pkg;

  localparam int DIGIT_COUNT = 4;
  localparam int IDX_W       = $clog2(DIGIT_COUNT);

  // Digit codes beyond 0..9 used by the display
  localparam logic [3:0] DIGIT_BLANK = 4'd10;
  localparam logic [3:0] DIGIT_DASH  = 4'd11;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low one-cold anode enable for scan position idx (bit 3 = leftmost)
  function automatic logic [DIGIT_COUNT-1:0] anode_for(input logic [IDX_W-1:0] idx);
    logic [DIGIT_COUNT-1:0] a;
    a      = '1;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/multiplexed_display_seven_seg_decoder.sv
// Digit code to active-low seven-segment pattern. Codes 0..9 are decimal
// digits, 10 is blank, 11 is a dash; anything else shows blank.
module seven_seg_decoder
  import multiplexed_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern; undefined codes stay dark
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:        seg = SEG_0;
      4'd1:        seg = SEG_1;
      4'd2:        seg = SEG_2;
      4'd3:        seg = SEG_3;
      4'd4:        seg = SEG_4;
      4'd5:        seg = SEG_5;
      4'd6:        seg = SEG_6;
      4'd7:        seg = SEG_7;
      4'd8:        seg = SEG_8;
      4'd9:        seg = SEG_9;
      DIGIT_BLANK: seg = SEG_BLANK;
      DIGIT_DASH:  seg = SEG_DASH;
      default:     seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multiplexed_display.sv
// Four-digit multiplexed seven-segment driver. A 2-bit scan index walks the
// digits 0,1,2,3 at the 500 Hz scan clock; each edge registers the segment,
// anode and colon drive for the current index while the index advances.
// Mode 0 shows free capacity and first empty slot, mode 1 shows MM:SS.
module multiplexed_display
  import multiplexed_display_pkg::*;
(
  input  logic       clk_500Hz,
  input  logic       reset,
  input  logic       mode,
  input  logic [2:0] capacity,
  input  logic [1:0] empty_slot,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [6:0] seg,
  output logic [3:0] anode,
  output logic       colon
);

  logic [IDX_W-1:0]       idx;
  logic [3:0]             digit_p0;
  logic [6:0]             seg_p0;
  logic [DIGIT_COUNT-1:0] anode_p0;
  logic                   colon_p0;

  // Decimal tens digit of a 0..63 value (at most 6, fits a digit code)
  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  // Decimal ones digit of a 0..63 value
  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  // ---- stage p0: choose the digit code for the current scan position ----
  // Select what the digit under idx should show, straight from the inputs
  always_comb begin
    digit_p0 = DIGIT_BLANK;
    if (mode) begin
      case (idx)
        2'd3:    digit_p0 = bcd_tens(minutes);
        2'd2:    digit_p0 = bcd_ones(minutes);
        2'd1:    digit_p0 = bcd_tens(seconds);
        default: digit_p0 = bcd_ones(seconds);
      endcase
    end else begin
      case (idx)
        2'd3:    digit_p0 = {1'b0, capacity};
        2'd2:    digit_p0 = DIGIT_BLANK;
        2'd1:    digit_p0 = DIGIT_BLANK;
        default: digit_p0 = (capacity == 3'd0) ? DIGIT_DASH : {2'b00, empty_slot};
      endcase
    end
  end

  seven_seg_decoder u_decoder (
    .digit (digit_p0),
    .seg   (seg_p0)
  );

  // Anode and colon drive for the digit under idx; colon lit only in time mode
  always_comb begin
    anode_p0 = anode_for(idx);
    colon_p0 = ~mode;
  end

  // ---- stage p1: registered outputs and scan index ----
  // Advance the scan and latch this digit's drive; reset darkens everything
  always_ff @(posedge clk_500Hz or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      seg   <= SEG_BLANK;
      anode <= '1;
      colon <= 1'b1;
    end else begin
      idx   <= idx + IDX_W'(1);
      seg   <= seg_p0;
      anode <= anode_p0;
      colon <= colon_p0;
    end
  end

endmodule

// File: tb/tb_multiplexed_display.sv
// Bench for multiplexed_display: directed scenarios plus randomized inputs,
// all checked against a digit-level reference model of the display.
`timescale 1us/1ns
module tb_multiplexed_display;

  logic       clk_500Hz = 1'b0;
  logic       reset     = 1'b0;
  logic       mode      = 1'b0;
  logic [2:0] capacity  = 3'd0;
  logic [1:0] empty_slot = 2'd0;
  logic [5:0] minutes   = 6'd0;
  logic [5:0] seconds   = 6'd0;
  logic [6:0] seg;
  logic [3:0] anode;
  logic       colon;

  int vectors     = 0;
  int miscompares = 0;
  int pos         = 0;   // digit the next edge will display
  logic [6:0] seg_tab [0:11];
  logic [6:0] scan_seg [0:3];
  logic       scan_colon [0:3];

  always #1000 clk_500Hz = ~clk_500Hz;

  multiplexed_display dut (
    .clk_500Hz  (clk_500Hz),
    .reset      (reset),
    .mode       (mode),
    .capacity   (capacity),
    .empty_slot (empty_slot),
    .minutes    (minutes),
    .seconds    (seconds),
    .seg        (seg),
    .anode      (anode),
    .colon      (colon)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Character shown on digit d for the present inputs (10 = blank, 11 = dash)
  function automatic int exp_char(input int d);
    if (mode) begin
      case (d)
        3:       return int'(minutes) / 10;
        2:       return int'(minutes) % 10;
        1:       return int'(seconds) / 10;
        default: return int'(seconds) % 10;
      endcase
    end else begin
      case (d)
        3:       return int'(capacity);
        2, 1:    return 10;
        default: return (capacity == 3'd0) ? 11 : int'(empty_slot);
      endcase
    end
  endfunction

  // One scan edge: outputs must show digit pos for the inputs held across the edge
  task automatic step(input string tag);
    int d;
    logic [3:0] exp_an;
    @(posedge clk_500Hz);
    #1;
    d   = pos;
    pos = (pos + 1) % 4;
    exp_an = 4'b1111;
    exp_an[d] = 1'b0;
    check_eq({tag, "_seg"},   32'(seg),   32'(seg_tab[exp_char(d)]));
    check_eq({tag, "_anode"}, 32'(anode), 32'(exp_an));
    check_eq({tag, "_colon"}, 32'(colon), mode ? 32'd0 : 32'd1);
    scan_seg[d]   = seg;
    scan_colon[d] = colon;
  endtask

  task automatic align_scan();
    while (pos != 0) step("align");
  endtask

  task automatic full_scan(input string tag);
    align_scan();
    for (int i = 0; i < 4; i++) step(tag);
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_seg"},   32'(seg),   32'h7F);
    check_eq({tag, "_anode"}, 32'(anode), 32'hF);
    check_eq({tag, "_colon"}, 32'(colon), 32'd1);
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b1111111; seg_tab[11] = 7'b0111111;

    // Reset held 5 ms: all dark
    #5000;
    check_dark("rst_hold");
    @(negedge clk_500Hz);
    reset = 1'b1;
    pos   = 0;

    // Anode walk after release
    step("walk0"); check_eq("walk0_an", 32'(anode), 32'b1110);
    step("walk1"); check_eq("walk1_an", 32'(anode), 32'b1101);
    step("walk2"); check_eq("walk2_an", 32'(anode), 32'b1011);
    step("walk3"); check_eq("walk3_an", 32'(anode), 32'b0111);

    // Mode 0, capacity 2, slot 1
    mode = 1'b0; capacity = 3'd2; empty_slot = 2'd1;
    full_scan("cap2");
    check_eq("cap2_d3", 32'(scan_seg[3]), 32'b0100100);
    check_eq("cap2_d2", 32'(scan_seg[2]), 32'b1111111);
    check_eq("cap2_d1", 32'(scan_seg[1]), 32'b1111111);
    check_eq("cap2_d0", 32'(scan_seg[0]), 32'b1111001);

    // Mode 0, capacity 4 slot 0, then capacity 0 -> dash
    capacity = 3'd4; empty_slot = 2'd0;
    full_scan("cap4");
    check_eq("cap4_d3", 32'(scan_seg[3]), 32'b0011001);
    check_eq("cap4_d0", 32'(scan_seg[0]), 32'b1000000);
    capacity = 3'd0;
    full_scan("cap0");
    check_eq("cap0_d0", 32'(scan_seg[0]), 32'b0111111);
    capacity = 3'd7;
    full_scan("cap7");
    check_eq("cap7_d3", 32'(scan_seg[3]), 32'b1111000);

    // Mode 1 time displays
    mode = 1'b1; minutes = 6'd5; seconds = 6'd3;
    full_scan("t0503");
    check_eq("t0503_d3", 32'(scan_seg[3]), 32'b1000000);
    check_eq("t0503_d2", 32'(scan_seg[2]), 32'b0010010);
    check_eq("t0503_d1", 32'(scan_seg[1]), 32'b1000000);
    check_eq("t0503_d0", 32'(scan_seg[0]), 32'b0110000);
    for (int i = 0; i < 4; i++) check_eq("t0503_col", 32'(scan_colon[i]), 32'd0);

    minutes = 6'd15; seconds = 6'd17; full_scan("t1517");
    check_eq("t1517_d2", 32'(scan_seg[2]), 32'b0010010);
    check_eq("t1517_d0", 32'(scan_seg[0]), 32'b1111000);
    minutes = 6'd20; seconds = 6'd40; full_scan("t2040");
    check_eq("t2040_d3", 32'(scan_seg[3]), 32'b0100100);
    check_eq("t2040_d1", 32'(scan_seg[1]), 32'b0011001);
    minutes = 6'd63; seconds = 6'd59; full_scan("t6359");
    check_eq("t6359_d3", 32'(scan_seg[3]), 32'b0000010);
    check_eq("t6359_d2", 32'(scan_seg[2]), 32'b0110000);
    check_eq("t6359_d0", 32'(scan_seg[0]), 32'b0010000);

    // Mode change mid-scan takes effect on the next edge without restarting
    step("mchg_a");
    mode = 1'b0; capacity = 3'd3; empty_slot = 2'd2;
    step("mchg_b");
    step("mchg_c");

    // Reset asserted while digit 2 is shown
    align_scan();
    step("pre_rst0"); step("pre_rst1"); step("pre_rst2");
    #300 reset = 1'b0;
    #1 check_dark("rst_mid");
    @(posedge clk_500Hz); #1 check_dark("rst_mid_e1");
    @(posedge clk_500Hz); #1 check_dark("rst_mid_e2");
    @(negedge clk_500Hz);
    reset = 1'b1;
    pos   = 0;
    step("post_rst");
    check_eq("post_rst_an", 32'(anode), 32'b1110);

    // Randomized inputs changed at random points between edges
    for (int n = 0; n < 300; n++) begin
      #($urandom_range(1, 1900));
      mode       = 1'($urandom_range(0, 1));
      capacity   = 3'($urandom_range(0, 7));
      empty_slot = 2'($urandom_range(0, 3));
      minutes    = 6'($urandom_range(0, 63));
      seconds    = 6'($urandom_range(0, 63));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multiplexed_display.md
MULTIPLEXED_DISPLAY -- requirements
Module: multiplexed_display

Interface
REQ-001 SHALL have ports: clk_500Hz  in  1  sole clock, 500 Hz scan clock, rising-edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: mode  in  1  display select: 0 = capacity/slot, 1 = time.
REQ-004 SHALL have: capacity  in  3  free-slot count, unsigned, nominal 0..4.
REQ-005 SHALL have: empty_slot  in  2  index of the first empty slot, 0..3.
REQ-006 SHALL have: minutes  in  6  elapsed minutes, unsigned, 0..63.
REQ-007 SHALL have: seconds  in  6  elapsed seconds, unsigned, 0..63.
REQ-008 SHALL have: seg  out  7  segment pattern {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have: anode  out  4  digit enables, active-low; bit 3 = leftmost digit, bit 0 = rightmost digit.
REQ-010 SHALL have: colon  out  1  colon enable, active-low.

Function
REQ-011 SHALL contain a 2-bit scan index idx that increments modulo 4 on every rising edge of clk_500Hz (4-clock refresh, 125 Hz per digit).
REQ-012 SHALL register seg, anode and colon; on each edge they take the decode of the current idx while idx advances.
REQ-013 The first edge after reset release SHALL drive digit 0; the sequence SHALL be 0,1,2,3,0,…
REQ-014 The anode pattern for digit k SHALL have only bit k low, e.g. digit 0 = 1110 and digit 3 = 0111.
REQ-015 Inputs SHALL be sampled combinationally at each edge; a change SHALL appear on the next scan of the affected digit, with no other latency.
REQ-016 Mode 0 digit contents:
- digit 3 = capacity as a decimal digit; values 5..7 are shown as 5..7.
- digits 2 and 1 = blank (seg 1111111).
- digit 0 = empty_slot as a digit 0..3, or dash (0111111) when capacity = 0.
- colon = 1 (off).
REQ-017 Mode 1 digit contents:
- digit 3 = minutes/10, digit 2 = minutes%10.
- digit 1 = seconds/10, digit 0 = seconds%10.
- colon = 0 (on) for every digit of the scan.
- Values up to 63 are displayed without saturation, e.g. 63 -> "63".
REQ-018 A mode change SHALL take effect on the next edge, with no reset of idx.
REQ-019 Segment codes, active-low, gfedcba:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- blank=1111111, dash=0111111
REQ-020 Digit values outside 0..9 SHALL NOT occur; the decoder default SHALL be blank.

Reset
REQ-021 While reset = 0, asynchronously: idx = 0, anode = 1111, seg = 1111111, colon = 1 (all dark).
REQ-022 Reset asserted mid-scan SHALL blank the outputs immediately, and scanning SHALL restart at digit 0 after release.

Structure
REQ-023 A shared package SHALL hold the segment code constants of REQ-019, plus DIGIT_COUNT=4 and the BLANK and DASH codes.
REQ-024 SHALL instantiate one sub-module, seven_seg_decoder, mapping a 4-bit digit code (0..9, 10=blank, 11=dash) to the 7-bit seg code.
REQ-025 Binary-to-decimal split of minutes and seconds SHALL be combinational (divide/modulo by 10 or an equivalent), within the same clock.

Verification
REQ-026 Hold reset=0 for 5 ms -> anode=1111, seg=1111111, colon=1; release -> anode steps 1110, 1101, 1011, 0111 on consecutive edges.
REQ-027 mode=0, capacity=2, empty_slot=1 -> one full scan shows:
- digit3 = 0100100, digit2 and digit1 = 1111111, digit0 = 1111001, colon = 1.
REQ-028 mode=0, capacity=4, empty_slot=0 -> digit3 = 0011001, digit0 = 1000000; then capacity=0 -> digit0 = 0111111 (dash).
REQ-029 mode=1, minutes=5, seconds=3 -> digits 0,5,0,3 ("05:03"), colon = 0 throughout.
REQ-030 mode=1, minutes=15, seconds=17, then minutes=20, seconds=40, then 63 and 59 -> "15:17", "20:40", "63:59", each within 4 edges of the input change.
REQ-031 Assert reset during digit 2 -> immediate blank, and the first post-release edge drives digit 0.
